// File: rtl/arb_mux_reg.sv
// rtl/arb_mux_reg.sv - round-robin N:1 arbiter feeding a single ready/valid output register
// Cyclic-priority winner selection from rr_ptr; winner's word is captured in one output slot.

module arb_mux_reg #(
  parameter int Ninputs = 2,
  parameter int Nbits   = 1
) (
  input  logic                                             clk,
  input  logic                                             resetn,
  input  logic [Ninputs-1:0]                               in_valid,
  input  logic [Ninputs*Nbits-1:0]                         in_data,
  output logic [Ninputs-1:0]                               in_ready,
  output logic                                             out_valid,
  output logic [Nbits-1:0]                                 out_data,
  input  logic                                             out_ready,
  output logic [((Ninputs > 1) ? $clog2(Ninputs) : 1)-1:0] grant_idx
);

  localparam int IW = (Ninputs > 1) ? $clog2(Ninputs) : 1;

  logic             out_valid_q, out_valid_d;
  logic [Nbits-1:0] out_data_q,  out_data_d;
  logic [IW-1:0]    grant_idx_q, grant_idx_d;
  logic [IW-1:0]    rr_ptr_q,    rr_ptr_d;

  logic          slot_free;
  logic          found;
  logic          xfer;
  logic [IW-1:0] win;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= Ninputs) s = s - Ninputs;
    return IW'(s);
  endfunction

  // Scan rr_ptr, rr_ptr+1, ... wrapping; first valid input wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < Ninputs; k++) begin
      if (!found && in_valid[wrap_idx(rr_ptr_q, k)]) begin
        found = 1'b1;
        win   = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    in_ready    = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;

    // Gating on resetn keeps any word from being accepted while reset is held.
    if (resetn && slot_free && found) in_ready[win] = 1'b1;
    xfer = |in_ready;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[Nbits*win +: Nbits];
      grant_idx_d = win;
      rr_ptr_d    = (win == IW'(Ninputs-1)) ? '0 : win + 1'b1;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// tb/tb_arb_mux_reg.sv - directed-vector bench for arb_mux_reg with a round-robin reference model
// Model state is updated on posedge; all checks happen on negedge.

module tb_arb_mux_reg;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [1:0]     grant_idx;

  int vectors     = 0;
  int miscompares = 0;

  int m_valid = 0;
  int m_data  = 0;
  int m_grant = 0;
  int m_ptr   = 0;

  arb_mux_reg #(.Ninputs(N), .Nbits(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Spec-level winner: first valid input counting up from the pointer modulo N.
  function automatic int model_winner();
    if (!resetn) return -1;
    if (m_valid != 0 && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int model_ready();
    int w;
    w = model_winner();
    return (w < 0) ? 0 : (1 << w);
  endfunction

  always @(posedge clk) begin
    int w;
    if (!resetn) begin
      m_valid = 0; m_data = 0; m_grant = 0; m_ptr = 0;
    end else begin
      w = model_winner();
      if (w >= 0) begin
        m_valid = 1;
        m_data  = int'(in_data[W*w +: W]);
        m_grant = w;
        m_ptr   = (w + 1) % N;
      end else if (m_valid == 0 || out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_in_ready",  int'(in_ready),  model_ready());
    chk("model_out_valid", int'(out_valid), m_valid);
    chk("model_out_data",  int'(out_data),  m_data);
    chk("model_grant_idx", int'(grant_idx), m_grant);
  end

  task automatic drv(input logic r, input logic [N-1:0] v, input logic o);
    @(posedge clk);
    #1;
    resetn    = r;
    in_valid  = v;
    out_ready = o;
  endtask

  task automatic set_std_data();
    for (int i = 0; i < N; i++) in_data[W*i +: W] = W'(8'h10 + i);
  endtask

  logic [N-1:0] tv [0:19];
  logic         to [0:19];

  initial begin
    resetn    = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    set_std_data();

    // Reset held for two edges with all inputs requesting.
    @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  8'h00);
    drv(1'b1, 4'b1111, 1'b1);
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 4'b0001);
    @(negedge clk);
    chk("first_out_data",  int'(out_data),  8'h10);
    chk("first_grant_idx", int'(grant_idx), 0);

    // Full-rate rotation.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("rot_out_data",  int'(out_data),  8'h10 + (k % 4));
      chk("rot_out_valid", int'(out_valid), 1);
    end

    // Backpressure while holding 0x11.
    drv(1'b1, 4'b1111, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_data", int'(out_data), 8'h11);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    drv(1'b1, 4'b1111, 1'b1);
    @(negedge clk);
    chk("bp_release_in_ready", int'(in_ready), 4'b0100);

    // Wrap-around from pointer 3 with inputs 0 and 3 valid.
    drv(1'b1, 4'b1001, 1'b1);
    @(negedge clk);
    chk("bp_next_out_data", int'(out_data), 8'h12);
    chk("wrap_in_ready3",   int'(in_ready), 4'b1000);
    @(negedge clk);
    chk("wrap_out_data3", int'(out_data), 8'h13);
    chk("wrap_in_ready0", int'(in_ready), 4'b0001);
    drv(1'b1, 4'b1111, 1'b1);
    @(negedge clk);
    chk("wrap_out_data0", int'(out_data), 8'h10);
    chk("wrap_ptr_is_1",  int'(in_ready), 4'b0010);

    // Drain a single word from input 1.
    drv(1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    chk("drain_out_valid", int'(out_valid), 1);
    chk("drain_out_data",  int'(out_data),  8'h11);
    chk("drain_grant_idx", int'(grant_idx), 1);
    @(negedge clk);
    chk("drain_out_valid_low", int'(out_valid), 0);
    chk("drain_out_data_held", int'(out_data),  8'h11);

    // Reset pulse while a word is held under backpressure.
    drv(1'b1, 4'b0100, 1'b1);
    @(negedge clk);
    chk("mid_load_in_ready", int'(in_ready), 4'b0100);
    drv(1'b1, 4'b1111, 1'b0);
    @(negedge clk);
    chk("mid_hold_out_data", int'(out_data), 8'h12);
    drv(1'b0, 4'b1111, 1'b0);
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    drv(1'b1, 4'b1111, 1'b0);
    @(negedge clk);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data",  int'(out_data),  8'h00);
    chk("mid_rst_grant_idx", int'(grant_idx), 0);
    chk("mid_rst_lowest",    int'(in_ready),  4'b0001);

    // Mixed directed patterns with changing data; checked by the model each cycle.
    tv[0]  = 4'b0110; to[0]  = 1'b1;
    tv[1]  = 4'b0110; to[1]  = 1'b1;
    tv[2]  = 4'b0110; to[2]  = 1'b0;
    tv[3]  = 4'b1010; to[3]  = 1'b0;
    tv[4]  = 4'b1010; to[4]  = 1'b1;
    tv[5]  = 4'b1010; to[5]  = 1'b1;
    tv[6]  = 4'b0001; to[6]  = 1'b1;
    tv[7]  = 4'b0000; to[7]  = 1'b0;
    tv[8]  = 4'b1100; to[8]  = 1'b1;
    tv[9]  = 4'b1111; to[9]  = 1'b1;
    tv[10] = 4'b1111; to[10] = 1'b0;
    tv[11] = 4'b1111; to[11] = 1'b1;
    tv[12] = 4'b0101; to[12] = 1'b1;
    tv[13] = 4'b0101; to[13] = 1'b1;
    tv[14] = 4'b0101; to[14] = 1'b1;
    tv[15] = 4'b1000; to[15] = 1'b1;
    tv[16] = 4'b0000; to[16] = 1'b1;
    tv[17] = 4'b0000; to[17] = 1'b1;
    tv[18] = 4'b0011; to[18] = 1'b0;
    tv[19] = 4'b0011; to[19] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drv(1'b1, tv[c], to[c]);
      for (int i = 0; i < N; i++) in_data[W*i +: W] = W'(8'hA0 + 3*i + 16*(c % 4));
    end
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_mux_reg.md
ARB_MUX_REG -- requirements
Module: arb_mux_reg

Interface
REQ-001 SHALL have parameter Ninputs, default 2, number of requesting inputs (>=1).
REQ-002 SHALL have parameter Nbits, default 1, width of each data word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  Ninputs  per-input request; bit i qualifies word i.
REQ-006 SHALL have port in_data  input  Ninputs*Nbits  word i at bits [Nbits*i +: Nbits].
REQ-007 SHALL have port in_ready  output  Ninputs  one-hot or zero; bit i high means word i is accepted this cycle if in_valid[i].
REQ-008 SHALL have port out_valid  output  1  output register holds a word.
REQ-009 SHALL have port out_data  output  Nbits  registered selected word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port grant_idx  output  $clog2(Ninputs) (min 1)  index of the input that supplied the current out_data.

Function
REQ-012 SHALL treat a transfer as occurring on a rising edge where valid and ready are both high, on either side.
REQ-013 SHALL define "slot free" combinationally as !out_valid || out_ready.
REQ-014 SHALL, when slot free, assert in_ready for exactly one input: the first i with in_valid[i]=1 scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, ..., wrapping at Ninputs-1 to 0); all other in_ready bits 0.
REQ-015 SHALL drive in_ready all-zero when slot not free or no in_valid is high.
REQ-016 SHALL make in_ready independent of in_data; combinational paths in_valid->in_ready and out_ready->in_ready are permitted.
REQ-017 SHALL, on an input transfer from winner w, load out_data <= word w, out_valid <= 1, grant_idx <= w, rr_ptr <= (w==Ninputs-1) ? 0 : w+1.
REQ-018 SHALL, when slot free and no input transfer, set out_valid <= 0 and hold out_data, grant_idx, rr_ptr.
REQ-019 SHALL, when slot not free, hold out_valid, out_data, grant_idx, rr_ptr unchanged.
REQ-020 SHALL have latency of exactly one cycle from input transfer to out_valid/out_data visible.
REQ-021 SHALL sustain one word per cycle when out_ready is held high and any in_valid is high.
REQ-022 SHALL, with Ninputs=1, reduce to a single pipeline register with ready/valid (rr_ptr constant 0).
REQ-023 SHALL never let an input win twice in a row while another input is continuously valid (fairness bound: Ninputs-1 other grants between two grants to the same continuously-valid input).

Reset
REQ-024 SHALL, on a clock edge with resetn=0, set out_valid=0, out_data=0, grant_idx=0, rr_ptr=0.
REQ-025 SHALL drive in_ready=0 combinationally whenever resetn=0, so no input transfer occurs during reset.
REQ-026 SHALL discard any word held at reset assertion, including mid-backpressure; first grant after release goes to the lowest-index valid input.

Verification (Ninputs=4, Nbits=8, word i = 0x10+i unless stated)
REQ-027 SHALL verify: resetn=0 for 2 cycles with in_valid=4'b1111, out_ready=1 -> in_ready=0, out_valid=0, out_data=0x00; first cycle after release in_ready=4'b0001, next cycle out_data=0x10, grant_idx=0.
REQ-028 SHALL verify: in_valid=4'b1111 and out_ready=1 continuously -> out_data 0x10,0x11,0x12,0x13,0x10 on consecutive cycles, out_valid never drops.
REQ-029 SHALL verify: out_valid=1 holding 0x11, out_ready=0 for 3 cycles -> out_data stays 0x11, in_ready=0; out_ready=1 -> in_ready=4'b0100 same cycle, out_data=0x12 next cycle.
REQ-030 SHALL verify wrap-around: rr_ptr=3 (after input 2 won), in_valid=4'b1001 -> input 3 wins (0x13), then input 0 (0x10), rr_ptr returns to 1.
REQ-031 SHALL verify drain: single word from input 1, then in_valid=0, out_ready=1 -> out_valid high one cycle with 0x11, then 0, out_data holds 0x11.
REQ-032 SHALL verify reset mid-backpressure: out_valid=1 holding 0x12, out_ready=0, resetn pulsed low 1 cycle -> out_valid=0, out_data=0x00, rr_ptr=0 after the edge.
